// File: rtl/mra_pkg.sv
// Shared types for the MRA request dispatcher: per-channel FSM states and the
// encoding driven on mra_rw.
package mra_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } ch_state_t;

    localparam logic MRA_RW_READ = 1'b0;

endpackage

// File: rtl/mra_ch_ctrl.sv
// One work-list channel: request/pop credit counters, address walker and the
// IDLE -> REQ -> DRAIN FSM. Port credit_blocked exists only with MRA_REQ_DISPATCHER_PERF_EN.
module mra_ch_ctrl
    import mra_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 64,
    parameter int unsigned WL_LEN_BITS  = 32,
    parameter int unsigned QUEUE_DEPTH  = 20,
    parameter int unsigned STRIDE_BYTES = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [WL_LEN_BITS-1:0] len,
    input  logic                   xfer,
    input  logic                   pop,
    output logic                   eligible,
    output logic [ADDR_WIDTH-1:0]  req_addr,
    output logic                   busy,
    output logic                   done,
    output logic                   underflow
`ifdef MRA_REQ_DISPATCHER_PERF_EN
    ,
    output logic                   credit_blocked
`endif
);

    localparam int unsigned CNT_W = WL_LEN_BITS + 1;
    localparam logic [CNT_W-1:0]      DEPTH  = CNT_W'(QUEUE_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(STRIDE_BYTES);

    ch_state_t              state;
    logic [CNT_W-1:0]       req_remain;
    logic [CNT_W-1:0]       pop_remain;
    logic [CNT_W-1:0]       req_nxt;
    logic [CNT_W-1:0]       pop_nxt;
    logic [CNT_W-1:0]       outstanding;
    logic [CNT_W-1:0]       req_load;
    logic [ADDR_WIDTH-1:0]  next_addr;
    logic                   pop_ok;

    assign outstanding = pop_remain - req_remain;
    assign pop_ok      = pop && (outstanding != '0);
    assign underflow   = pop && (outstanding == '0);
    assign req_load    = ({1'b0, len} + CNT_W'(1)) >> 1;

    assign req_nxt = req_remain - CNT_W'(xfer);
    assign pop_nxt = pop_remain - CNT_W'(pop_ok);

    // Eligibility looks at post-edge counters so a transfer or pop this cycle
    // is already accounted for when the arbiter loads the next request.
    assign eligible = (state == REQ) && (req_nxt != '0) && ((pop_nxt - req_nxt) < DEPTH);
    assign req_addr = xfer ? (next_addr + STRIDE) : next_addr;

`ifdef MRA_REQ_DISPATCHER_PERF_EN
    assign credit_blocked = (state == REQ) && (req_remain != '0) && (outstanding >= DEPTH);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_remain <= '0;
            pop_remain <= '0;
            next_addr  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done       <= 1'b0;
            req_remain <= req_nxt;
            pop_remain <= pop_nxt;
            if (xfer) begin
                next_addr <= next_addr + STRIDE;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= REQ;
                        busy       <= 1'b1;
                        req_remain <= req_load;
                        pop_remain <= req_load;
                        next_addr  <= base_addr;
                    end
                end
                REQ: begin
                    if (req_nxt == '0) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop_nxt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mra_req_dispatcher.sv
// Multi-channel read-request dispatcher: round-robin arbitration over channel
// controllers onto one registered valid/ready request port. Optional perf counters under MRA_REQ_DISPATCHER_PERF_EN.
module mra_req_dispatcher
    import mra_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 64,
    parameter int unsigned WL_LEN_BITS  = 32,
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned QUEUE_DEPTH  = 20,
    parameter int unsigned STRIDE_BYTES = 64
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic [NUM_CH-1:0]                                 start,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]                      wl_addr,
    input  logic [NUM_CH*WL_LEN_BITS-1:0]                     wl_len,
    output logic [NUM_CH-1:0]                                 busy,
    output logic [NUM_CH-1:0]                                 done,
    output logic [ADDR_WIDTH-1:0]                             mra_req_addr,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]    mra_req_ch,
    output logic                                              mra_rw,
    output logic                                              mra_req_valid,
    input  logic                                              mra_ready,
    input  logic [NUM_CH-1:0]                                 fifo_pop,
`ifdef MRA_REQ_DISPATCHER_PERF_EN
    output logic [31:0]                                       stall_cycles,
    output logic [31:0]                                       credit_block_cycles,
`endif
    output logic                                              err_underflow
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]     ch_elig;
    logic [NUM_CH-1:0]     ch_xfer;
    logic [NUM_CH-1:0]     ch_underflow;
    logic [ADDR_WIDTH-1:0] ch_addr [NUM_CH];
`ifdef MRA_REQ_DISPATCHER_PERF_EN
    logic [NUM_CH-1:0]     ch_blocked;
`endif

    logic                  gnt_any;
    logic [CH_W-1:0]       gnt_idx;
    logic [CH_W-1:0]       rr_ptr;
    logic [CH_W-1:0]       ptr_nxt;

    assign mra_rw = MRA_RW_READ;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_xfer[i] = mra_req_valid && mra_ready && (mra_req_ch == CH_W'(i));

        mra_ch_ctrl #(
            .ADDR_WIDTH   (ADDR_WIDTH),
            .WL_LEN_BITS  (WL_LEN_BITS),
            .QUEUE_DEPTH  (QUEUE_DEPTH),
            .STRIDE_BYTES (STRIDE_BYTES)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start[i]),
            .base_addr (wl_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
            .len       (wl_len[i*WL_LEN_BITS +: WL_LEN_BITS]),
            .xfer      (ch_xfer[i]),
            .pop       (fifo_pop[i]),
            .eligible  (ch_elig[i]),
            .req_addr  (ch_addr[i]),
            .busy      (busy[i]),
            .done      (done[i]),
            .underflow (ch_underflow[i])
`ifdef MRA_REQ_DISPATCHER_PERF_EN
            ,
            .credit_blocked (ch_blocked[i])
`endif
        );
    end

    // Two passes: first from the pointer upward, then wrap to the low channels.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!gnt_any && ch_elig[i] && (i >= 32'(rr_ptr))) begin
                gnt_any = 1'b1;
                gnt_idx = CH_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!gnt_any && ch_elig[i]) begin
                gnt_any = 1'b1;
                gnt_idx = CH_W'(i);
            end
        end
    end

    assign ptr_nxt = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mra_req_valid <= 1'b0;
            mra_req_addr  <= '0;
            mra_req_ch    <= '0;
            rr_ptr        <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (|ch_underflow) begin
                err_underflow <= 1'b1;
            end
            if (!mra_req_valid || mra_ready) begin
                mra_req_valid <= gnt_any;
                if (gnt_any) begin
                    mra_req_addr <= ch_addr[gnt_idx];
                    mra_req_ch   <= gnt_idx;
                    rr_ptr       <= ptr_nxt;
                end
            end
        end
    end

`ifdef MRA_REQ_DISPATCHER_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles        <= '0;
            credit_block_cycles <= '0;
        end else begin
            if (mra_req_valid && !mra_ready && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if ((|ch_blocked) && (credit_block_cycles != '1)) begin
                credit_block_cycles <= credit_block_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/mra_req_dispatcher.md
MRA_REQ_DISPATCHER -- requirements
Module: mra_req_dispatcher

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, request address width.
REQ-002 SHALL have parameter WL_LEN_BITS, default 32, work-list length width (entries).
REQ-003 SHALL have parameter NUM_CH, default 4, independent work-list channels (1..16).
REQ-004 SHALL have parameter QUEUE_DEPTH, default 20, per-channel outstanding-request credit limit (>=1).
REQ-005 SHALL have parameter STRIDE_BYTES, default 64, address increment per request.
REQ-006 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports: start  in  NUM_CH  per-channel start pulse; wl_addr  in  NUM_CH*ADDR_WIDTH  base addresses; wl_len  in  NUM_CH*WL_LEN_BITS  lengths.
REQ-008 SHALL have ports: busy  out  NUM_CH  channel active; done  out  NUM_CH  one-cycle completion pulse.
REQ-009 SHALL have ports: mra_req_addr  out  ADDR_WIDTH; mra_req_ch  out  $clog2(NUM_CH) (min 1); mra_rw  out  1  tied 0 (read); mra_req_valid  out  1; mra_ready  in  1.
REQ-010 SHALL have ports: fifo_pop  in  NUM_CH  per-channel consumer pop; err_underflow  out  1  sticky pop-without-outstanding flag.

Function
REQ-011 Per channel, SHALL run FSM IDLE -> REQ -> DRAIN -> IDLE; busy=1 in REQ and DRAIN.
REQ-012 In IDLE, start[i]=1 SHALL load req_remain=ceil(wl_len/2) (WL_LEN_BITS+1 bits, no overflow), pop_remain=same, next_addr=wl_addr; go REQ next cycle.
REQ-013 start[i] while busy[i]=1 SHALL be ignored.
REQ-014 wl_len=0 SHALL pass REQ->DRAIN->IDLE issuing no request; done pulses the cycle the channel enters IDLE (2 cycles after start).
REQ-015 Channel i eligible when in REQ, req_remain>0 and outstanding=(pop_remain-req_remain)<QUEUE_DEPTH.
REQ-016 Round-robin arbiter SHALL pick one eligible channel, priority starting after the last granted channel; after reset pointer favors channel 0.
REQ-017 Valid/ready: once mra_req_valid=1, mra_req_addr and mra_req_ch SHALL hold stable until mra_ready=1 in the same cycle; no re-arbitration while pending.
REQ-018 Transfer (valid&ready) SHALL decrement req_remain and add STRIDE_BYTES to next_addr (mod 2^ADDR_WIDTH) for the granted channel; a new grant may be presented the next cycle (1 request/cycle max).
REQ-019 mra_req_valid SHALL be registered; first request appears 1 cycle after channel enters REQ.
REQ-020 REQ->DRAIN when req_remain reaches 0; DRAIN->IDLE when pop_remain reaches 0; done[i] pulses that cycle.
REQ-021 fifo_pop[i] with outstanding>0 SHALL decrement pop_remain; with outstanding=0 (incl. IDLE) SHALL be ignored and set err_underflow.
REQ-022 Same-cycle transfer and pop on one channel SHALL both apply; outstanding unchanged.
REQ-023 Outstanding=QUEUE_DEPTH SHALL block the channel; a pop SHALL make it eligible the following cycle.

Reset
REQ-024 rst_n low SHALL immediately force all FSMs IDLE, counters/addresses 0, mra_req_valid=0, mra_req_addr=0, mra_req_ch=0, busy=0, done=0, err_underflow=0, arbiter pointer 0, including mid-transfer.
REQ-025 Deassertion SHALL be synchronised by the integrator; first accepted start on the first clk edge with rst_n high.

Configuration
REQ-026 Macro MRA_REQ_DISPATCHER_PERF_EN defined SHALL add outputs stall_cycles (32 bits: cycles valid=1 & ready=0) and credit_block_cycles (32 bits: cycles any REQ channel blocked by REQ-023), saturating, reset 0.
REQ-027 Without MRA_REQ_DISPATCHER_PERF_EN those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-028 Package mra_pkg SHALL hold ch_state_t enum {IDLE, REQ, DRAIN} and MRA_RW_READ constant.
REQ-029 Per-channel FSM/counters SHALL be sub-module mra_ch_ctrl, instantiated NUM_CH times via generate; arbiter and output register stay in top.

Verification
REQ-030 NUM_CH=1, wl_len=5, wl_addr=0x1000, ready=1, pops prompt -> 3 requests 0x1000,0x1040,0x1080 on consecutive cycles, done once after 3rd pop.
REQ-031 wl_len=0 start -> no mra_req_valid, done pulse 2 cycles after start, busy low after.
REQ-032 QUEUE_DEPTH=2, wl_len=10, no pops -> exactly 2 requests then valid low; one pop -> 3rd request next cycle.
REQ-033 4 channels started together, ready=1 -> mra_req_ch sequence 0,1,2,3,0,...; ready low 3 cycles mid-burst -> addr/ch stable, stall_cycles=3 with PERF_EN.
REQ-034 fifo_pop[2] while channel 2 IDLE -> err_underflow=1 and sticky; rst_n low mid-burst -> all outputs 0 same cycle.
